// File: rtl/l1icache_param.sv
// Direct-mapped L1 instruction cache with parametrised line size and set count,
// multi-beat Wishbone-style burst refill, invalidate-all and hit/miss counters.
module l1icache_param #(
    parameter int ADDR_LEN    = 32,
    parameter int WB_DATA_LEN = 32,
    parameter int LINE_WORDS  = 4,
    parameter int SETS        = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [ADDR_LEN-1:0]    req_addr_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic [ADDR_LEN-1:0]    resp_addr_o,
    output logic [WB_DATA_LEN-1:0] resp_data_o,
    output logic                   resp_err_o,
    input  logic                   flush_i,
    output logic                   flush_done_o,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic                   wb_we_o,
    output logic [ADDR_LEN-1:0]    wb_adr_o,
    output logic [9:0]             wb_bl_o,
    input  logic                   wb_ack_i,
    input  logic [WB_DATA_LEN-1:0] wb_dat_i,
    input  logic                   wb_err_i,
    output logic [31:0]            hit_cnt_o,
    output logic [31:0]            miss_cnt_o
);
    localparam int WL  = $clog2(LINE_WORDS);
    localparam int OFF = WL + 2;
    localparam int IDX = $clog2(SETS);
    localparam int TAG = ADDR_LEN - IDX - OFF;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_REFILL = 3'd2;
    localparam logic [2:0] S_RESP   = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;

    localparam logic [WL-1:0]  LAST_BEAT = WL'(LINE_WORDS - 1);
    localparam logic [IDX-1:0] LAST_SET  = IDX'(SETS - 1);

    logic [2:0]             state;
    logic                   pend_flush;
    logic [ADDR_LEN-1:0]    addr_q;
    logic [WB_DATA_LEN-1:0] rdata_q;
    logic                   err_q;
    logic [WL-1:0]          beat;
    logic [IDX-1:0]         flush_idx;
    logic [31:0]            hit_cnt;
    logic [31:0]            miss_cnt;
    logic [SETS-1:0]        valid;
    logic [TAG-1:0]         tag_mem  [SETS];
    logic [WB_DATA_LEN-1:0] data_mem [SETS][LINE_WORDS];

    logic [TAG-1:0] a_tag;
    logic [IDX-1:0] a_idx;
    logic [WL-1:0]  a_word;
    logic           hit;

    assign a_tag  = addr_q[ADDR_LEN-1 -: TAG];
    assign a_idx  = addr_q[OFF +: IDX];
    assign a_word = addr_q[2 +: WL];
    assign hit    = valid[a_idx] && (tag_mem[a_idx] == a_tag);

    // A same-cycle flush_i wins over the request, so ready drops to keep the request waiting.
    assign req_ready_o  = (state == S_IDLE) && !pend_flush && !flush_i;
    assign resp_valid_o = (state == S_RESP);
    assign resp_addr_o  = addr_q;
    assign resp_data_o  = rdata_q;
    assign resp_err_o   = err_q;
    assign flush_done_o = (state == S_FLUSH) && (flush_idx == LAST_SET);
    assign wb_cyc_o     = (state == S_REFILL);
    assign wb_stb_o     = wb_cyc_o;
    assign wb_we_o      = 1'b0;
    assign wb_adr_o     = wb_cyc_o ? {addr_q[ADDR_LEN-1:OFF], beat, 2'b00} : '0;
    assign wb_bl_o      = wb_cyc_o ? 10'(LINE_WORDS) : '0;
    assign hit_cnt_o    = hit_cnt;
    assign miss_cnt_o   = miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pend_flush <= 1'b0;
            addr_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            beat       <= '0;
            flush_idx  <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            valid      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (flush_i || pend_flush) begin
                        state      <= S_FLUSH;
                        pend_flush <= 1'b0;
                        flush_idx  <= '0;
                    end else if (req_valid_i) begin
                        addr_q <= req_addr_i;
                        state  <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    err_q <= 1'b0;
                    if (hit) begin
                        rdata_q <= data_mem[a_idx][a_word];
                        hit_cnt <= hit_cnt + 32'd1;
                        state   <= S_RESP;
                    end else begin
                        miss_cnt     <= miss_cnt + 32'd1;
                        valid[a_idx] <= 1'b0;
                        beat         <= '0;
                        state        <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (wb_err_i) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state   <= S_RESP;
                    end else if (wb_ack_i) begin
                        data_mem[a_idx][beat] <= wb_dat_i;
                        if (beat == a_word) begin
                            rdata_q <= wb_dat_i;
                        end
                        if (beat == LAST_BEAT) begin
                            tag_mem[a_idx] <= a_tag;
                            valid[a_idx]   <= 1'b1;
                            state          <= S_RESP;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (resp_ready_i) begin
                        state <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    valid[flush_idx] <= 1'b0;
                    if (flush_idx == LAST_SET) begin
                        state <= S_IDLE;
                    end else begin
                        flush_idx <= flush_idx + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (flush_i && (state == S_LOOKUP || state == S_REFILL || state == S_RESP)) begin
                pend_flush <= 1'b1;
            end
        end
    end
endmodule

// File: doc/l1icache_param.md
# l1icache_param

Parametrised direct-mapped L1 instruction cache, the next generation of the fixed 32-bit, two-word-line icache. It sits between the fetch stage and the Wishbone-style memory bus. It serves one fetch at a time over a valid/ready handshake. Line size and set count are configurable, and the block adds per-set valid bits, a multi-beat burst refill, bus-error reporting, a fence.i-style invalidate-all and hit/miss counters. Tag, valid and data storage are internal flop arrays.

## Interface
- ADDR_LEN, 32: fetch/bus address width.
- WB_DATA_LEN, 32: bus and instruction word width; only 32 is supported.
- LINE_WORDS, 4: words per line; power of 2, ≥2.
- SETS, 64: number of sets; power of 2, ≥2.
- Derived widths: OFF = log2(LINE_WORDS)+2, IDX = log2(SETS), TAG = ADDR_LEN−IDX−OFF.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- req_valid_i  in  1  fetch request valid.
- req_ready_o  out  1  block can accept a request.
- req_addr_i  in  ADDR_LEN  fetch address; bits [1:0] are ignored.
- resp_valid_o  out  1  response valid; held until accepted.
- resp_ready_i  in  1  consumer accepts the response.
- resp_addr_o  out  ADDR_LEN  address of the request being answered.
- resp_data_o  out  32  instruction word.
- resp_err_o  out  1  bus error during refill; resp_data_o = 0 when set.
- flush_i  in  1  invalidate-all request (single-cycle pulse).
- flush_done_o  out  1  one-cycle pulse when the invalidate completes.
- wb_cyc_o / wb_stb_o  out  1  bus cycle and strobe; always equal.
- wb_we_o  out  1  constant 0.
- wb_adr_o  out  ADDR_LEN  current beat address.
- wb_bl_o  out  10  burst length = LINE_WORDS while cyc is high, 0 otherwise.
- wb_ack_i  in  1  beat data valid.
- wb_dat_i  in  32  beat data.
- wb_err_i  in  1  bus error; terminates the burst.
- hit_cnt_o, miss_cnt_o  out  32  wrapping lookup counters.

## Operation
- Address split: tag = addr[ADDR_LEN−1:IDX+OFF], index = addr[IDX+OFF−1:OFF], word = addr[OFF−1:2].
- FSM states: IDLE, LOOKUP, REFILL, RESP, FLUSH.
- IDLE, input selection:
  - req_ready_o = 1 only in IDLE with no pending flush.
  - flush_i or a pending flush takes priority over a same-cycle request and moves the FSM to FLUSH.
  - Otherwise, a request handshake latches the address and moves the FSM to LOOKUP.
- LOOKUP:
  - Hit (valid[index] and stored tag == tag): capture data[index][word], increment hit_cnt_o, go to RESP.
  - Miss: increment miss_cnt_o, clear valid[index], go to REFILL.
- REFILL, burst sequencing:
  - wb_cyc_o = 1. wb_adr_o starts at the line-aligned address and advances by 4 after each wb_ack_i.
  - Beat k is written to data[index][k]; beat number `word` is captured as the response data.
  - After the LINE_WORDS-th ack: write the tag, set valid[index], drop cyc on the next cycle, go to RESP.
- REFILL, error and ack rules:
  - wb_err_i aborts the burst: drop cyc, leave valid[index]=0, go to RESP with resp_err_o=1.
  - If ack and err are high in the same cycle, err wins.
  - Acks outside REFILL are ignored.
- RESP: resp_valid_o=1, with data, error and address held stable. On resp_ready_i, return to IDLE.
- FLUSH:
  - A counter walks index 0..SETS−1, clearing one valid bit per cycle.
  - After index SETS−1, pulse flush_done_o and return to IDLE.
  - flush_i during FLUSH is absorbed.
- flush_i arriving outside IDLE/FLUSH sets a pending flag; it runs after the current response completes. The line filled by that in-flight miss is invalidated by it.
- Counters wrap modulo 2^32.

## Timing
- Reset values: all valid bits 0, FSM=IDLE, pending flush 0, counters 0.
- Output reset values: req_ready_o=1, resp_valid_o=0, resp_err_o=0, resp_data_o=0, resp_addr_o=0, flush_done_o=0, wb_cyc_o=wb_stb_o=0, wb_adr_o=0, wb_bl_o=0.
- Hit latency: handshake at edge T; LOOKUP in T+1; resp_valid_o high from T+2.
- Next request: earliest handshake is the cycle after the response handshake.
- Miss timing: wb_cyc_o rises in the cycle after LOOKUP. resp_valid_o rises in the cycle after the last ack, with wb_cyc_o low in that same cycle.
- Flush length: FLUSH lasts exactly SETS cycles; flush_done_o pulses in the last of them.
- Reset in mid-operation (any state, including mid-burst): all state returns to reset values on that edge. The bus slave tolerates a cyc drop.
- Stall hold: with resp_ready_i=0 the response is held indefinitely and no bus activity occurs.

## Test plan
- Cold miss then hit, default parameters:
  - Fetch 0x0000_1008. Expect wb_adr_o sequence 0x1000, 0x1004, 0x1008, 0x100C with wb_bl_o=4; resp_data_o = beat 2; miss_cnt_o=1.
  - Then fetch 0x100C. Expect no bus cycle; resp 2 cycles after handshake with beat 3; hit_cnt_o=1.
- Conflict: fetch 0x0000_1000, then 0x0000_2000 (same index, default SETS=64) -> second access misses and refills. Re-fetching 0x1000 then misses again.
- Bus error: wb_err_i on beat 2 of a refill -> cyc drops, resp_err_o=1, resp_data_o=0. A retry of the same address misses.
- Flush: flush_i while in RESP with resp_ready_i=0 -> flush runs after the response handshake, flush_done_o pulses SETS cycles later, and a previously cached address misses.
- Backpressure and priority:
  - Hold resp_ready_i=0 for 10 cycles -> resp_valid_o, resp_data_o and resp_addr_o stay stable, and req_ready_o=0.
  - flush_i and req_valid_i in the same IDLE cycle -> FLUSH is entered and the request waits.
- Reset mid-burst after 2 acks -> wb_cyc_o=0 and valid bits cleared next cycle; the same address then misses.
- LINE_WORDS=8, SETS=16: 8-beat refill with wrapping counters checked.
